// File: rtl/matmul_job_sequencer.sv
// matmul_job_sequencer: APB master that runs one matrix-multiply job.
// Writes the control word (start bit forced high) to the accelerator, waits
// for busy to rise and then fall, reads the flags register back, then pulses
// done_o with an error code.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   job_valid_i/job_ready_o   job handshake; job_ctrl_i sampled on accept
//   done_o, err_o, flags_o    completion pulse, error code, flags read-back
//   psel_o .. paddr_o         APB master request signals
//   pready_i, pslverr_i,
//   prdata_i                  APB slave response
//   busy_i                    accelerator busy
module matmul_job_sequencer #(
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned MAX_DIM        = 4,
  parameter int unsigned CTRL_ADDR      = 32'h0000,
  parameter int unsigned FLAGS_ADDR     = 32'h0010,
  parameter int unsigned START_BIT      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [BUS_WIDTH-1:0]  job_ctrl_i,
  output logic                  done_o,
  output logic [1:0]            err_o,
  output logic [BUS_WIDTH-1:0]  flags_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  busy_i
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; it saturates at all-ones.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  localparam logic [BUS_WIDTH-1:0] START_MASK = BUS_WIDTH'(1) << START_BIT;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_SLV     = 2'd1;
  localparam logic [1:0] ERR_START_T = 2'd2;
  localparam logic [1:0] ERR_DONE_T  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_ACCESS,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_RD_SETUP,
    ST_RD_ACCESS,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                    timeout_hit;
  logic                    ready_d, done_d, psel_d, penable_d, pwrite_d;
  logic [MAX_DIM-1:0]      pstrb_d;
  logic [BUS_WIDTH-1:0]    pwdata_d, flags_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [1:0]              err_d;

  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next state and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = pwrite_o;
    pstrb_d   = pstrb_o;
    pwdata_d  = pwdata_o;
    paddr_d   = paddr_o;
    err_d     = err_o;
    flags_d   = flags_o;

    case (state_q)
      ST_IDLE: begin
        if (job_valid_i && job_ready_o) begin
          state_d  = ST_WR_SETUP;
          psel_d   = 1'b1;
          pwrite_d = 1'b1;
          paddr_d  = ADDR_WIDTH'(CTRL_ADDR);
          pwdata_d = job_ctrl_i | START_MASK;
          pstrb_d  = '1;
          err_d    = ERR_OK;
          flags_d  = '0;
        end
      end
      ST_WR_SETUP: begin
        state_d   = ST_WR_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ST_WR_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        if (pready_i) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (pslverr_i) begin
            err_d   = ERR_SLV;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_START;
          end
        end
      end
      // Busy check has priority over the timeout check.
      ST_WAIT_START: begin
        if (busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (timeout_hit) begin
          err_d   = ERR_START_T;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_i) begin
          state_d  = ST_RD_SETUP;
          psel_d   = 1'b1;
          pwrite_d = 1'b0;
          paddr_d  = ADDR_WIDTH'(FLAGS_ADDR);
          pstrb_d  = '0;
          pwdata_d = '0;
        end else if (timeout_hit) begin
          err_d   = ERR_DONE_T;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RD_SETUP: begin
        state_d   = ST_RD_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ST_RD_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        if (pready_i) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          flags_d   = prdata_i;
          if (pslverr_i) err_d = ERR_SLV;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE) && !busy_i;
    done_d  = (state_d == ST_DONE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      job_ready_o <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= ERR_OK;
      flags_o     <= '0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      pstrb_o     <= '0;
      pwdata_o    <= '0;
      paddr_o     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      job_ready_o <= ready_d;
      done_o      <= done_d;
      err_o       <= err_d;
      flags_o     <= flags_d;
      psel_o      <= psel_d;
      penable_o   <= penable_d;
      pwrite_o    <= pwrite_d;
      pstrb_o     <= pstrb_d;
      pwdata_o    <= pwdata_d;
      paddr_o     <= paddr_d;
    end
  end

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Directed bench for matmul_job_sequencer: one instance with the default
// timeout for protocol tests, one with TIMEOUT_CYCLES = 8 for timeout tests.
module tb_matmul_job_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready, done, psel, penable, pwrite;
  logic        pready, pslverr, busy;
  logic [31:0] job_ctrl, flags, pwdata, prdata;
  logic [1:0]  err;
  logic [3:0]  pstrb;
  logic [15:0] paddr;

  logic        t_valid, t_ready, t_done, t_psel, t_penable, t_pwrite, t_busy;
  logic [31:0] t_flags, t_pwdata;
  logic [1:0]  t_err;
  logic [3:0]  t_pstrb;
  logic [15:0] t_paddr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  matmul_job_sequencer u_dut (
    .clk_i(clk), .rst_i(rst),
    .job_valid_i(job_valid), .job_ready_o(job_ready), .job_ctrl_i(job_ctrl),
    .done_o(done), .err_o(err), .flags_o(flags),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .pstrb_o(pstrb),
    .pwdata_o(pwdata), .paddr_o(paddr),
    .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata), .busy_i(busy)
  );

  matmul_job_sequencer #(.TIMEOUT_CYCLES(8)) u_to (
    .clk_i(clk), .rst_i(rst),
    .job_valid_i(t_valid), .job_ready_o(t_ready), .job_ctrl_i(job_ctrl),
    .done_o(t_done), .err_o(t_err), .flags_o(t_flags),
    .psel_o(t_psel), .penable_o(t_penable), .pwrite_o(t_pwrite), .pstrb_o(t_pstrb),
    .pwdata_o(t_pwdata), .paddr_o(t_paddr),
    .pready_i(1'b1), .pslverr_i(1'b0), .prdata_i(32'h77), .busy_i(t_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int psel_cnt;
    int ready_cnt;
    logic [31:0] hold_wdata;

    rst = 1'b1; job_valid = 1'b0; job_ctrl = '0; pready = 1'b1; pslverr = 1'b0;
    prdata = '0; busy = 1'b0; t_valid = 1'b0; t_busy = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_psel", 32'(psel), 0);
    check("rst_penable", 32'(penable), 0);
    check("rst_pwrite", 32'(pwrite), 0);
    check("rst_pstrb", 32'(pstrb), 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_paddr", 32'(paddr), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_flags", flags, 0);
    check("rst_ready", 32'(job_ready), 0);
    rst = 1'b0;
    tick();
    check("idle_ready", 32'(job_ready), 1);

    // Nominal job, zero-wait slave
    job_ctrl = 32'h0000_0020; job_valid = 1'b1; prdata = 32'h5;
    tick();
    job_valid = 1'b0;
    check("nom_wsetup_psel", 32'(psel), 1);
    check("nom_wsetup_pen", 32'(penable), 0);
    check("nom_wsetup_pwrite", 32'(pwrite), 1);
    check("nom_wsetup_paddr", 32'(paddr), 32'h0);
    check("nom_wsetup_pwdata", pwdata, 32'h21);
    check("nom_wsetup_pstrb", 32'(pstrb), 32'hF);
    check("nom_ready_busy", 32'(job_ready), 0);
    tick();
    check("nom_waccess_pen", 32'(penable), 1);
    tick();
    check("nom_wdone_psel", 32'(psel), 0);
    tick();
    busy = 1'b1;
    tick();
    repeat (20) tick();
    check("nom_wait_psel", 32'(psel), 0);
    check("nom_wait_done", 32'(done), 0);
    busy = 1'b0;
    tick();
    check("nom_rsetup_psel", 32'(psel), 1);
    check("nom_rsetup_pen", 32'(penable), 0);
    check("nom_rsetup_pwrite", 32'(pwrite), 0);
    check("nom_rsetup_paddr", 32'(paddr), 32'h10);
    check("nom_rsetup_pstrb", 32'(pstrb), 0);
    check("nom_rsetup_pwdata", pwdata, 0);
    tick();
    check("nom_raccess_pen", 32'(penable), 1);
    tick();
    check("nom_done", 32'(done), 1);
    check("nom_err", 32'(err), 0);
    check("nom_flags", flags, 32'h5);
    check("nom_done_psel", 32'(psel), 0);
    tick();
    check("nom_done_pulse", 32'(done), 0);
    check("nom_ready_back", 32'(job_ready), 1);
    check("nom_flags_hold", flags, 32'h5);

    // Wait states: 3 on each transfer
    pready = 1'b0; job_ctrl = 32'hA5A5_0000; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    check("ws_wsetup_pen", 32'(penable), 0);
    hold_wdata = 32'hA5A5_0001;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("ws_w_pen", 32'(penable), 1);
      check("ws_w_psel", 32'(psel), 1);
      check("ws_w_paddr", 32'(paddr), 0);
      check("ws_w_pwdata", pwdata, hold_wdata);
      check("ws_w_pwrite", 32'(pwrite), 1);
      if (i == 3) pready = 1'b1;
      tick();
    end
    pready = 1'b0;
    check("ws_w_end_psel", 32'(psel), 0);
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    check("ws_rsetup_psel", 32'(psel), 1);
    check("ws_rsetup_pen", 32'(penable), 0);
    prdata = 32'h0000_CAFE;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("ws_r_pen", 32'(penable), 1);
      check("ws_r_paddr", 32'(paddr), 32'h10);
      check("ws_r_pwrite", 32'(pwrite), 0);
      if (i == 3) pready = 1'b1;
      tick();
    end
    check("ws_done", 32'(done), 1);
    check("ws_flags", flags, 32'hCAFE);
    check("ws_err", 32'(err), 0);
    tick();

    // Slave error on the write: no read issued
    pslverr = 1'b1; job_ctrl = 32'h0000_0100; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    tick();
    tick();
    pslverr = 1'b0;
    check("serr_done", 32'(done), 1);
    check("serr_err", 32'(err), 1);
    check("serr_flags", flags, 0);
    psel_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (psel) psel_cnt++;
    end
    check("serr_no_read", 32'(psel_cnt), 0);
    check("serr_err_hold", 32'(err), 1);

    // Reset asserted during WR_ACCESS
    pready = 1'b0; job_ctrl = 32'h0000_0040; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    tick();
    check("rma_pen_before", 32'(penable), 1);
    #1 rst = 1'b1;
    #1;
    check("rma_psel_async", 32'(psel), 0);
    check("rma_pen_async", 32'(penable), 0);
    #1 rst = 1'b0;
    pready = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || psel) n++;
    end
    check("rma_no_done", 32'(n), 0);
    check("rma_idle_ready", 32'(job_ready), 1);

    // Start timeout on the TIMEOUT_CYCLES = 8 instance
    check("sto_ready", 32'(t_ready), 1);
    job_ctrl = 32'h0000_0002; t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    check("sto_pwdata", t_pwdata, 32'h3);
    check("sto_paddr", 32'(t_paddr), 0);
    check("sto_pstrb", 32'(t_pstrb), 32'hF);
    check("sto_pwrite", 32'(t_pwrite), 1);
    check("sto_flags_clr", t_flags, 0);
    tick();
    check("sto_pen", 32'(t_penable), 1);
    tick();
    n = 0;
    while (!t_done && n < 20) begin
      tick();
      n++;
    end
    check("sto_latency", 32'(n), 8);
    check("sto_err", 32'(t_err), 2);
    tick();
    check("sto_ready_back", 32'(t_ready), 1);

    // Done timeout with job_valid held during the job
    t_valid = 1'b1;
    tick();
    tick();
    t_busy = 1'b1;
    tick();
    tick();
    n = 0; psel_cnt = 0; ready_cnt = 0;
    while (!t_done && n < 20) begin
      tick();
      n++;
      if (t_psel) psel_cnt++;
      if (t_ready) ready_cnt++;
    end
    check("dto_latency", 32'(n), 8);
    check("dto_err", 32'(t_err), 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (t_psel) psel_cnt++;
      if (t_ready) ready_cnt++;
    end
    check("dto_no_second_write", 32'(psel_cnt), 0);
    check("dto_ready_low", 32'(ready_cnt), 0);
    t_busy = 1'b0;
    tick();
    check("dto_ready_after_busy", 32'(t_ready), 1);
    t_valid = 1'b0;
    tick();
    check("dto_idle_psel", 32'(t_psel), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_job_sequencer.md
Name: matmul_job_sequencer

Overview:
APB master that runs one matrix-multiply job on the matmul accelerator's APB slave port. For each accepted job it writes the control word with the start bit set, then tracks the slave's busy_o through start and completion. It then reads the flags register, reports status and returns to idle. It sits between the system job source and the matmul APB slave, and gives a single owner to start, poll and completion handling.

Parameters:
BUS_WIDTH, 32, APB data width (matches matmul_pkg).
ADDR_WIDTH, 16, APB address width.
MAX_DIM, 4, strobe width (BUS_WIDTH/8).
CTRL_ADDR, 'h0000, control register address.
FLAGS_ADDR, 'h0010, flags register address.
START_BIT, 0, bit index of start in the control word.
TIMEOUT_CYCLES, 4096, wait-state limit; 0 disables timeouts.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous reset, active-high.
job_valid_i  in  1  job request.
job_ready_o  out  1  sequencer can accept a job.
job_ctrl_i  in  BUS_WIDTH  control word; sampled on accept.
done_o  out  1  one-cycle job-complete pulse.
err_o  out  2  0 = ok, 1 = APB slave error, 2 = start timeout, 3 = done timeout.
flags_o  out  BUS_WIDTH  flags register read-back.
psel_o  out  1  APB select.
penable_o  out  1  APB enable.
pwrite_o  out  1  APB write.
pstrb_o  out  MAX_DIM  APB strobes.
pwdata_o  out  BUS_WIDTH  APB write data.
paddr_o  out  ADDR_WIDTH  APB address.
pready_i  in  1  slave ready.
pslverr_i  in  1  slave error, valid with pready_i.
prdata_i  in  BUS_WIDTH  slave read data.
busy_i  in  1  accelerator busy.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. An asynchronous reset mid-job drops psel_o/penable_o immediately, abandons the transfer and raises no done_o.
- All outputs are registered. The FSM states are IDLE, WR_SETUP, WR_ACCESS, WAIT_START, WAIT_DONE, RD_SETUP, RD_ACCESS and DONE.
- IDLE:
  - job_ready_o = 1 only when busy_i = 0.
  - On job_valid_i & job_ready_o: latch job_ctrl_i with bit START_BIT forced to 1, clear err_o and flags_o to 0, go to WR_SETUP.
  - job_valid_i outside IDLE is ignored; job_ready_o = 0 there.
- WR_SETUP (exactly 1 cycle):
  - psel = 1, penable = 0, pwrite = 1, paddr = CTRL_ADDR.
  - pwdata = latched word, pstrb = all ones.
- WR_ACCESS:
  - penable = 1; address, data and strobes are held stable.
  - Wait for pready_i, with no timeout on pready.
  - pready & pslverr → err = 1, go to DONE.
  - pready & !pslverr → go to WAIT_START.
  - psel/penable drop in the cycle after pready.
- WAIT_START:
  - Wait for busy_i = 1, then go to WAIT_DONE.
- WAIT_DONE:
  - Wait for busy_i = 0, then go to RD_SETUP.
- Timeout (WAIT_START and WAIT_DONE):
  - A counter is cleared on entering each wait state and increments every cycle.
  - Reaching TIMEOUT_CYCLES while busy_i is still in its old state sets err = 2 (WAIT_START) or 3 (WAIT_DONE) and goes to DONE.
  - The timeout check follows the busy check: busy_i changing in the same cycle the limit is hit counts as success.
- RD_SETUP / RD_ACCESS:
  - Same APB protocol as the write, with pwrite = 0, paddr = FLAGS_ADDR, pstrb = 0, pwdata = 0.
  - On pready, capture prdata_i into flags_o.
  - pslverr → err = 1; flags_o keeps the captured value.
  - Then go to DONE.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
- err_o and flags_o hold their values until the next job is accepted.
- Latency with a zero-wait-state slave: accept → WR_SETUP in 1 cycle, write 2 cycles, read 2 cycles. done_o asserts 1 cycle after the read's pready.
- The counter saturates and never wraps. TIMEOUT_CYCLES = 0 means wait forever.

Test Plan:
- Nominal job, zero-wait slave:
  - Stimulus: job_ctrl = 'h0000_0020; busy rises 2 cycles after the write and falls 20 cycles later; flags read returns 'h5.
  - Required: write observed with pwdata = 'h21, pstrb = 'hF, addr 'h0; read at 'h10; done_o pulse with err = 0, flags = 'h5; job_ready back to 1.
- Wait states:
  - Stimulus: slave inserts 3 wait states on both transfers.
  - Required: paddr, pwdata and pwrite remain stable throughout ACCESS; exactly one setup cycle per transfer.
- Write slave error:
  - Stimulus: pslverr = 1 on the write.
  - Required: no read transfer is issued; done_o with err = 1.
- Start timeout:
  - Stimulus: TIMEOUT_CYCLES = 8; busy never rises.
  - Required: done_o 8 cycles after entering WAIT_START, err = 2.
- Done timeout plus ignored request:
  - Stimulus: TIMEOUT_CYCLES = 8; busy stuck high; job_valid held during the job.
  - Required: err = 3; no second write while busy; job_ready stays 0 until busy falls.
- Reset mid-ACCESS:
  - Stimulus: assert rst_i during WR_ACCESS.
  - Required: psel/penable go to 0 asynchronously, no done_o, state is IDLE after release.
